packetizer_serial: RTL and testbench

//  Streaming successor to the parallel 3-flit packetizer. Takes one data word plus a destination
//  and serialises it into a packet of NUM_FLITS flits, one flit per cycle, on a FLIT_WIDTH NoC

---
 rtl/packetizer_pkg.sv | 35 +++
 rtl/packetizer_flit_fmt.sv | 62 ++++++
 rtl/packetizer_serial.sv | 132 +++++++++++++
 tb/tb_packetizer_serial.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/packetizer_pkg.sv
// Shared types, flit header layout and packet-geometry helpers for the serial packetizer.
package packetizer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } pkt_state_t;

   localparam int FLIT_HDR_BITS = 3;

   // Header bit positions counted down from the flit MSB.
   localparam int FLIT_VALID_BIT = 0;
   localparam int FLIT_HEAD_BIT  = 1;
   localparam int FLIT_TAIL_BIT  = 2;

   function automatic int head_payload_w(input int flit_w, input int addr_w, input int vc_w);
      return flit_w - FLIT_HDR_BITS - vc_w - addr_w;
   endfunction

   function automatic int body_payload_w(input int flit_w, input int vc_w);
      return flit_w - FLIT_HDR_BITS - vc_w;
   endfunction

   function automatic int calc_num_flits(input int width_in, input int flit_w,
                                         input int addr_w, input int vc_w);
      int head_pl;
      int body_pl;
      int rem;
      head_pl = head_payload_w(flit_w, addr_w, vc_w);
      body_pl = body_payload_w(flit_w, vc_w);
      rem     = (width_in > head_pl) ? (width_in - head_pl) : 0;
      return 1 + (rem + body_pl - 1) / body_pl;
   endfunction

endpackage

// File: rtl/packetizer_flit_fmt.sv
// Combinational flit formatter: selects the payload slice for flit idx and adds the header.
module packetizer_flit_fmt
   import packetizer_pkg::*;
#(
   parameter int ADDRESS_WIDTH    = 4,
   parameter int VC_ADDRESS_WIDTH = 1,
   parameter int WIDTH_IN         = 64,
   parameter int FLIT_WIDTH       = 36,
   parameter int ASSIGNED_VC      = 0,
   parameter int NUM_FLITS        = calc_num_flits(WIDTH_IN, FLIT_WIDTH, ADDRESS_WIDTH, VC_ADDRESS_WIDTH),
   parameter int CNT_W            = $clog2(NUM_FLITS + 1)
) (
   input  logic                     valid,
   input  logic [WIDTH_IN-1:0]      data,
   input  logic [ADDRESS_WIDTH-1:0] dst,
   input  logic [CNT_W-1:0]         idx,
   input  logic [CNT_W-1:0]         last,
   output logic [FLIT_WIDTH-1:0]    flit
);

   localparam int HEAD_PL  = head_payload_w(FLIT_WIDTH, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
   localparam int BODY_PL  = body_payload_w(FLIT_WIDTH, VC_ADDRESS_WIDTH);
   localparam int TOTAL_PL = HEAD_PL + (NUM_FLITS - 1) * BODY_PL;
   localparam int PAD_W    = TOTAL_PL - WIDTH_IN;

   // Data left-aligned in the full packet payload so the tail pad lands at the LSBs.
   logic [TOTAL_PL-1:0] padded;
   logic [BODY_PL-1:0]  body_seg [NUM_FLITS];
   logic [BODY_PL-1:0]  sel_body;

   assign padded = TOTAL_PL'(data) << PAD_W;

   generate
      for (genvar gi = 0; gi < NUM_FLITS; gi++) begin : g_seg
         if (gi == 0) begin : g_head
            assign body_seg[gi] = {dst, padded[TOTAL_PL-1 -: HEAD_PL]};
         end else begin : g_body
            assign body_seg[gi] = padded[TOTAL_PL-1-HEAD_PL-(gi-1)*BODY_PL -: BODY_PL];
         end
      end
   endgenerate

   always_comb begin
      sel_body = '0;
      for (int i = 0; i < NUM_FLITS; i++) begin
         if (idx == CNT_W'(i)) begin
            sel_body = body_seg[i];
         end
      end
   end

   always_comb begin
      flit = '0;
      if (valid) begin
         flit = {{FLIT_HDR_BITS{1'b0}}, VC_ADDRESS_WIDTH'(ASSIGNED_VC), sel_body};
         flit[FLIT_WIDTH-1-FLIT_VALID_BIT] = 1'b1;
         flit[FLIT_WIDTH-1-FLIT_HEAD_BIT]  = (idx == '0);
         flit[FLIT_WIDTH-1-FLIT_TAIL_BIT]  = (idx == last);
      end
   end

endmodule

// File: rtl/packetizer_serial.sv
// Serialises one data word + destination into a NUM_FLITS-flit NoC packet with ready/valid flow.
// Optional feature macro: PACKETIZER_VARLEN_EN adds len_in for per-packet flit counts.
module packetizer_serial
   import packetizer_pkg::*;
#(
   parameter int ADDRESS_WIDTH    = 4,
   parameter int VC_ADDRESS_WIDTH = 1,
   parameter int WIDTH_IN         = 64,
   parameter int FLIT_WIDTH       = 36,
   parameter int ASSIGNED_VC      = 0,
   localparam int NUM_FLITS       = calc_num_flits(WIDTH_IN, FLIT_WIDTH, ADDRESS_WIDTH, VC_ADDRESS_WIDTH),
   localparam int CNT_W           = $clog2(NUM_FLITS + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH_IN-1:0]      data_in,
   input  logic [ADDRESS_WIDTH-1:0] dst_in,
   input  logic                     valid_in,
`ifdef PACKETIZER_VARLEN_EN
   input  logic [CNT_W-1:0]         len_in,
`endif
   output logic                     ready_out,
   output logic [FLIT_WIDTH-1:0]    data_out,
   output logic                     valid_out,
   input  logic                     ready_in
);

   pkt_state_t               state_reg, state_next;
   logic [CNT_W-1:0]         idx_reg, idx_next;
   logic [CNT_W-1:0]         last_reg;
   logic [WIDTH_IN-1:0]      data_reg;
   logic [ADDRESS_WIDTH-1:0] dst_reg;
   logic [CNT_W-1:0]         len_last;
   logic                     at_last;
   logic                     accept;
   logic                     flit_hs;
   logic                     load;

`ifdef PACKETIZER_VARLEN_EN
   // Out-of-range lengths fall back to the full packet.
   always_comb begin
      len_last = CNT_W'(NUM_FLITS - 1);
      if (len_in != '0 && len_in <= CNT_W'(NUM_FLITS)) begin
         len_last = len_in - CNT_W'(1);
      end
   end
`else
   assign len_last = CNT_W'(NUM_FLITS - 1);
`endif

   assign at_last = (idx_reg == last_reg);

   always_comb begin
      ready_out  = 1'b0;
      valid_out  = 1'b0;
      state_next = state_reg;
      idx_next   = idx_reg;
      load       = 1'b0;

      // ready_in reaches ready_out combinationally so a new word can follow the tail directly.
      if (!rst) begin
         valid_out = (state_reg == ST_SEND);
         ready_out = (state_reg == ST_IDLE) || ((state_reg == ST_SEND) && at_last && ready_in);
      end
      accept  = valid_in && ready_out;
      flit_hs = valid_out && ready_in;

      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               state_next = ST_SEND;
               idx_next   = '0;
               load       = 1'b1;
            end
         end
         ST_SEND: begin
            if (flit_hs) begin
               if (at_last) begin
                  idx_next = '0;
                  if (accept) begin
                     load = 1'b1;
                  end else begin
                     state_next = ST_IDLE;
                  end
               end else begin
                  idx_next = idx_reg + CNT_W'(1);
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
            idx_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         idx_reg   <= '0;
         last_reg  <= '0;
         data_reg  <= '0;
         dst_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         if (load) begin
            data_reg <= data_in;
            dst_reg  <= dst_in;
            last_reg <= len_last;
         end
      end
   end

   packetizer_flit_fmt #(
      .ADDRESS_WIDTH    (ADDRESS_WIDTH),
      .VC_ADDRESS_WIDTH (VC_ADDRESS_WIDTH),
      .WIDTH_IN         (WIDTH_IN),
      .FLIT_WIDTH       (FLIT_WIDTH),
      .ASSIGNED_VC      (ASSIGNED_VC),
      .NUM_FLITS        (NUM_FLITS),
      .CNT_W            (CNT_W)
   ) u_flit_fmt (
      .valid (valid_out),
      .data  (data_reg),
      .dst   (dst_reg),
      .idx   (idx_reg),
      .last  (last_reg),
      .flit  (data_out)
   );

endmodule

// File: tb/tb_packetizer_serial.sv
// Scoreboard bench for packetizer_serial: default 64-bit instance plus a single-flit WIDTH_IN=20 instance.
module tb_packetizer_serial;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] data_in = '0;
   logic [3:0]  dst_in = '0;
   logic        valid_in = 1'b0;
   logic        ready_out;
   logic [35:0] data_out;
   logic        valid_out;
   logic        ready_in = 1'b0;

   logic [19:0] d2_data = '0;
   logic [3:0]  d2_dst = '0;
   logic        d2_valid_in = 1'b0;
   logic        d2_ready_out;
   logic [35:0] d2_data_out;
   logic        d2_valid_out;
   logic        d2_ready_in = 1'b0;

`ifdef PACKETIZER_VARLEN_EN
   logic [1:0]  len_in = '0;
   logic [0:0]  d2_len = '0;
`endif

   int vectors     = 0;
   int miscompares = 0;
   logic [35:0] sb [$];

   always #5 clk = ~clk;

   packetizer_serial dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .dst_in    (dst_in),
      .valid_in  (valid_in),
`ifdef PACKETIZER_VARLEN_EN
      .len_in    (len_in),
`endif
      .ready_out (ready_out),
      .data_out  (data_out),
      .valid_out (valid_out),
      .ready_in  (ready_in)
   );

   packetizer_serial #(.WIDTH_IN(20)) dut_w20 (
      .clk       (clk),
      .rst       (rst),
      .data_in   (d2_data),
      .dst_in    (d2_dst),
      .valid_in  (d2_valid_in),
`ifdef PACKETIZER_VARLEN_EN
      .len_in    (d2_len),
`endif
      .ready_out (d2_ready_out),
      .data_out  (d2_data_out),
      .valid_out (d2_valid_out),
      .ready_in  (d2_ready_in)
   );

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference flit built bit by bit: payload bits walk data_in MSB-first across flits.
   function automatic logic [35:0] exp_flit(input logic [63:0] data, input int width_in,
                                            input logic [3:0] dst, input int idx, input int last);
      logic [35:0] f;
      int start;
      int pl;
      int k;
      f     = '0;
      f[35] = 1'b1;
      f[34] = (idx == 0);
      f[33] = (idx == last);
      if (idx == 0) begin
         f[31:28] = dst;
         pl       = 28;
         start    = 0;
      end else begin
         pl    = 32;
         start = 28 + (idx - 1) * 32;
      end
      for (int b = 0; b < pl; b++) begin
         k = start + b;
         f[pl-1-b] = (k < width_in) ? data[width_in-1-k] : 1'b0;
      end
      return f;
   endfunction

   always @(negedge clk) begin
      int n;
      if (rst) begin
         sb.delete();
      end else begin
         check_val("vbit", {63'd0, data_out[35]}, {63'd0, valid_out});
         if (!valid_out) check_val("idle_zero", {28'd0, data_out}, 64'd0);
         if (valid_out && ready_in) begin
            if (sb.size() == 0) check_val("sb_empty", 64'(sb.size()), 64'd1);
            else check_val("sb_flit", {28'd0, data_out}, {28'd0, sb.pop_front()});
         end
         if (valid_in && ready_out) begin
            n = 3;
`ifdef PACKETIZER_VARLEN_EN
            if (len_in != 2'd0) n = int'(len_in);
`endif
            for (int i = 0; i < n; i++) sb.push_back(exp_flit(data_in, 64, dst_in, i, n - 1));
            $display("accept data=%h dst=%h flits=%0d", data_in, dst_in, n);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_s1(input string tag);
      logic [35:0] f0;
      logic [35:0] f1;
      logic [35:0] f2;
      f0 = {4'b1100, 4'h5, 28'h0123456};
      f1 = {4'b1000, 32'h789ABCDE};
      f2 = {4'b1010, 4'hF, 28'h0};
      tick();
      data_in = 64'h0123456789ABCDEF; dst_in = 4'h5; valid_in = 1'b1; ready_in = 1'b1;
      @(negedge clk); check_val({tag, "_rdy"}, {63'd0, ready_out}, 64'd1);
      tick(); valid_in = 1'b0;
      @(negedge clk); check_val({tag, "_f0"}, {28'd0, data_out}, {28'd0, f0});
      tick();
      @(negedge clk); check_val({tag, "_f1"}, {28'd0, data_out}, {28'd0, f1});
      tick();
      @(negedge clk); check_val({tag, "_f2"}, {28'd0, data_out}, {28'd0, f2});
      check_val({tag, "_tail_rdy"}, {63'd0, ready_out}, 64'd1);
      tick();
      @(negedge clk); check_val({tag, "_idle"}, {63'd0, valid_out}, 64'd0);
   endtask

   initial begin
      logic [63:0] w;
      logic [3:0]  d;
      logic        b_acc;
      // reset state
      repeat (2) begin
         @(negedge clk);
         check_val("rst_ready", {63'd0, ready_out}, 64'd0);
         check_val("rst_valid", {63'd0, valid_out}, 64'd0);
         check_val("rst_data", {28'd0, data_out}, 64'd0);
      end
      tick(); rst = 1'b0;
      @(negedge clk); check_val("post_rst_ready", {63'd0, ready_out}, 64'd1);

      run_s1("s1");

      // stall on the second flit
      w = {$urandom, $urandom}; d = 4'($urandom);
      tick(); data_in = w; dst_in = d; valid_in = 1'b1; ready_in = 1'b1;
      @(negedge clk); check_val("s2_rdy", {63'd0, ready_out}, 64'd1);
      tick(); valid_in = 1'b0;
      @(negedge clk); check_val("s2_head", {28'd0, data_out}, {28'd0, exp_flit(w, 64, d, 0, 2)});
      tick(); ready_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         @(negedge clk);
         check_val("s2_hold", {28'd0, data_out}, {28'd0, exp_flit(w, 64, d, 1, 2)});
         check_val("s2_hold_v", {63'd0, valid_out}, 64'd1);
         check_val("s2_hold_rdy", {63'd0, ready_out}, 64'd0);
      end
      tick(); ready_in = 1'b1;
      @(negedge clk); check_val("s2_release", {28'd0, data_out}, {28'd0, exp_flit(w, 64, d, 1, 2)});
      tick();
      @(negedge clk); check_val("s2_tail", {28'd0, data_out}, {28'd0, exp_flit(w, 64, d, 2, 2)});
      tick();

      // two words back to back
      tick(); data_in = {$urandom, $urandom}; dst_in = 4'($urandom); valid_in = 1'b1;
      @(negedge clk); check_val("s3_acc_a", {63'd0, ready_out}, 64'd1);
      tick(); data_in = {$urandom, $urandom}; dst_in = 4'($urandom);
      b_acc = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_val("s3_cont", {63'd0, valid_out}, 64'd1);
         check_val("s3_head", {63'd0, data_out[34]}, {63'd0, (i % 3) == 0});
         check_val("s3_rdy", {63'd0, ready_out}, {63'd0, (i % 3) == 2});
         if (valid_in && ready_out) b_acc = 1'b1;
         tick();
         if (b_acc) valid_in = 1'b0;
      end
      @(negedge clk); check_val("s3_done", {63'd0, valid_out}, 64'd0);

      // reset right after the head flit
      w = {$urandom, $urandom}; d = 4'($urandom);
      tick(); data_in = w; dst_in = d; valid_in = 1'b1;
      @(negedge clk); check_val("s4_rdy", {63'd0, ready_out}, 64'd1);
      tick(); valid_in = 1'b0;
      @(negedge clk); check_val("s4_head", {28'd0, data_out}, {28'd0, exp_flit(w, 64, d, 0, 2)});
      tick(); rst = 1'b1;
      @(negedge clk);
      check_val("s4_rst_v", {63'd0, valid_out}, 64'd0);
      check_val("s4_rst_d", {28'd0, data_out}, 64'd0);
      check_val("s4_rst_rdy", {63'd0, ready_out}, 64'd0);
      tick(); rst = 1'b0;
      @(negedge clk);
      check_val("s4_post_rdy", {63'd0, ready_out}, 64'd1);
      check_val("s4_post_v", {63'd0, valid_out}, 64'd0);
      w = {$urandom, $urandom}; d = 4'($urandom);
      tick(); data_in = w; dst_in = d; valid_in = 1'b1;
      @(negedge clk);
      tick(); valid_in = 1'b0;
      @(negedge clk); check_val("s4_new_head", {28'd0, data_out}, {28'd0, exp_flit(w, 64, d, 0, 2)});
      repeat (2) tick();

      // single-flit packets at WIDTH_IN=20
      tick(); d2_data = 20'hABCDE; d2_dst = 4'h9; d2_valid_in = 1'b1; d2_ready_in = 1'b0;
      @(negedge clk); check_val("s5_rdy", {63'd0, d2_ready_out}, 64'd1);
      tick(); d2_valid_in = 1'b0;
      @(negedge clk);
      check_val("s5_flit", {28'd0, d2_data_out}, {28'd0, 4'b1110, 4'h9, 20'hABCDE, 8'h00});
      check_val("s5_stall_rdy", {63'd0, d2_ready_out}, 64'd0);
      tick(); d2_ready_in = 1'b1;
      @(negedge clk); check_val("s5_tail_rdy", {63'd0, d2_ready_out}, 64'd1);
      tick();
      @(negedge clk);
      check_val("s5_after_v", {63'd0, d2_valid_out}, 64'd0);
      check_val("s5_after_rdy", {63'd0, d2_ready_out}, 64'd1);
      check_val("s5_after_d", {28'd0, d2_data_out}, 64'd0);

`ifdef PACKETIZER_VARLEN_EN
      tick(); data_in = 64'h0123456789ABCDEF; dst_in = 4'h3; len_in = 2'd1; valid_in = 1'b1;
      @(negedge clk); check_val("s6_rdy", {63'd0, ready_out}, 64'd1);
      tick(); valid_in = 1'b0; len_in = 2'd0;
      @(negedge clk); check_val("s6_len1", {28'd0, data_out}, {28'd0, 4'b1110, 4'h3, 28'h0123456});
      tick();
      @(negedge clk); check_val("s6_len1_done", {63'd0, valid_out}, 64'd0);
      run_s1("s6_len0");
`endif

      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      check_val("sb_drain", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

endmodule
